// File: rtl/instr_issue_ctrl.sv
// Instruction issue controller: buffers 8-bit instructions, decodes the head,
// stalls on register hazards via a busy scoreboard and drains at HALT.
module instr_issue_ctrl #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_instruction,
    output logic             issue_valid,
    input  logic             issue_ready,
    output logic [3:0]       issue_op_code,
    output logic [1:0]       issue_src,
    output logic [1:0]       issue_dst,
    input  logic             done_valid,
    input  logic [1:0]       done_dst,
    output logic [3:0]       busy,
    output logic             halted,
    input  logic             resume,
    output logic [CNT_W-1:0] fifo_count
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic {
        RUN,
        HALTED
    } state_t;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    state_t           state;
    state_t           state_next;
    logic             empty;
    logic             full;
    logic             push;
    logic             pop;
    logic             set_busy;
    logic [7:0]       head;
    logic [3:0]       busy_next;

    assign empty      = (count == '0);
    assign full       = (count == CNT_W'(FIFO_DEPTH));
    // No pop-bypass: a full buffer refuses input even when the head leaves this cycle.
    assign in_ready   = !rst && !full;
    assign push       = in_valid && in_ready;
    assign head       = empty ? 8'h00 : mem[rd_ptr];

    assign issue_op_code = head[7:4];
    assign issue_src     = head[3:2];
    assign issue_dst     = head[1:0];
    assign halted        = (state == HALTED);
    assign fifo_count    = count;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_instruction;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            busy  <= '0;
        end else begin
            state <= state_next;
            busy  <= busy_next;
        end
    end

    always_comb begin
        state_next  = state;
        pop         = 1'b0;
        issue_valid = 1'b0;
        set_busy    = 1'b0;
        if (state == RUN) begin
            if (!empty) begin
                case (issue_op_code)
                    4'h0: pop = 1'b1;
                    4'hF: begin
                        // HALT drains: every outstanding write must retire first.
                        if (busy == 4'b0000) begin
                            pop        = 1'b1;
                            state_next = HALTED;
                        end
                    end
                    default: begin
                        issue_valid = !busy[issue_src] && !busy[issue_dst];
                        if (issue_valid && issue_ready) begin
                            pop      = 1'b1;
                            set_busy = 1'b1;
                        end
                    end
                endcase
            end
        end else if (resume) begin
            state_next = RUN;
        end
    end

    // Clear first, then set, so a same-cycle issue to a completing register stays busy.
    always_comb begin
        busy_next = busy;
        if (done_valid) begin
            busy_next[done_dst] = 1'b0;
        end
        if (set_busy) begin
            busy_next[issue_dst] = 1'b1;
        end
    end
endmodule

// File: tb/tb_instr_issue_ctrl.sv
// Bench for instr_issue_ctrl: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_instr_issue_ctrl;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_instruction = 8'h00;
    logic       issue_valid;
    logic       issue_ready = 1'b0;
    logic [3:0] issue_op_code;
    logic [1:0] issue_src;
    logic [1:0] issue_dst;
    logic       done_valid = 1'b0;
    logic [1:0] done_dst = 2'd0;
    logic [3:0] busy;
    logic       halted;
    logic       resume = 1'b0;
    logic [2:0] fifo_count;

    int n_cmp = 0;
    int n_err = 0;

    instr_issue_ctrl #(.FIFO_DEPTH(DEPTH), .CNT_W(3)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_instruction(in_instruction),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_op_code(issue_op_code), .issue_src(issue_src), .issue_dst(issue_dst),
        .done_valid(done_valid), .done_dst(done_dst),
        .busy(busy), .halted(halted), .resume(resume), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: pending instructions, pending-write registers, halt flag.
    logic [7:0] mq[$];
    logic [3:0] mbusy = 4'b0000;
    bit         mhalt = 1'b0;

    function automatic logic [7:0] m_head();
        if (mq.size() == 0) return 8'h00;
        return mq[0];
    endfunction

    function automatic bit m_issue_valid();
        logic [7:0] h;
        if (mhalt || mq.size() == 0) return 1'b0;
        h = mq[0];
        if (h[7:4] == 4'h0 || h[7:4] == 4'hF) return 1'b0;
        return !mbusy[h[3:2]] && !mbusy[h[1:0]];
    endfunction

    initial begin
        bit         do_pop;
        bit         do_set;
        bit         do_push;
        bit         nh;
        logic [7:0] h;
        logic [3:0] nb;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                mq.delete();
                mbusy = 4'b0000;
                mhalt = 1'b0;
            end else begin
                do_pop  = 1'b0;
                do_set  = 1'b0;
                nh      = mhalt;
                h       = m_head();
                do_push = in_valid && (mq.size() < DEPTH);
                if (!mhalt && mq.size() > 0) begin
                    if (h[7:4] == 4'h0) begin
                        do_pop = 1'b1;
                    end else if (h[7:4] == 4'hF) begin
                        if (mbusy == 4'b0000) begin
                            do_pop = 1'b1;
                            nh     = 1'b1;
                        end
                    end else if (m_issue_valid() && issue_ready) begin
                        do_pop = 1'b1;
                        do_set = 1'b1;
                    end
                end else if (mhalt && resume) begin
                    nh = 1'b0;
                end
                nb = mbusy;
                if (done_valid) nb[done_dst] = 1'b0;
                if (do_set) nb[h[1:0]] = 1'b1;
                if (do_pop) void'(mq.pop_front());
                if (do_push) mq.push_back(in_instruction);
                mbusy = nb;
                mhalt = nh;
            end
        end
    end

    initial begin
        logic [7:0] h;
        forever begin
            @(negedge clk);
            h = m_head();
            chk("m_issue_valid", {15'd0, issue_valid}, {15'd0, m_issue_valid()});
            chk("m_issue_op", {12'd0, issue_op_code}, {12'd0, h[7:4]});
            chk("m_issue_src", {14'd0, issue_src}, {14'd0, h[3:2]});
            chk("m_issue_dst", {14'd0, issue_dst}, {14'd0, h[1:0]});
            chk("m_busy", {12'd0, busy}, {12'd0, mbusy});
            chk("m_halted", {15'd0, halted}, {15'd0, mhalt});
            chk("m_fifo_count", {13'd0, fifo_count}, 16'(mq.size()));
            chk("m_in_ready", {15'd0, in_ready}, {15'd0, (!rst && mq.size() < DEPTH)});
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push1(input logic [7:0] instr);
        in_valid       = 1'b1;
        in_instruction = instr;
        cyc();
        in_valid = 1'b0;
    endtask

    task automatic done1(input logic [1:0] r);
        done_valid = 1'b1;
        done_dst   = r;
        cyc();
        done_valid = 1'b0;
    endtask

    initial begin
        // Reset behaviour
        cyc();
        chk("rst_in_ready", {15'd0, in_ready}, 16'd0);
        chk("rst_count", {13'd0, fifo_count}, 16'd0);
        chk("rst_issue_valid", {15'd0, issue_valid}, 16'd0);
        rst = 1'b0;
        cyc();
        chk("post_rst_in_ready", {15'd0, in_ready}, 16'd1);
        chk("post_rst_busy", {12'd0, busy}, 16'd0);

        // Single instruction, minimum latency
        issue_ready = 1'b1;
        push1(8'h16);
        chk("t1_issue_valid", {15'd0, issue_valid}, 16'd1);
        chk("t1_op", {12'd0, issue_op_code}, 16'd1);
        chk("t1_src", {14'd0, issue_src}, 16'd1);
        chk("t1_dst", {14'd0, issue_dst}, 16'd2);
        cyc();
        chk("t1_busy", {12'd0, busy}, 16'h4);
        done1(2'd2);
        chk("t1_busy_clr", {12'd0, busy}, 16'h0);

        // RAW hazard on r2
        in_valid = 1'b1; in_instruction = 8'h16; cyc();
        in_instruction = 8'h29; cyc();
        in_valid = 1'b0;
        chk("t2_stall_valid", {15'd0, issue_valid}, 16'd0);
        chk("t2_stall_count", {13'd0, fifo_count}, 16'd1);
        cyc();
        chk("t2_still_stalled", {15'd0, issue_valid}, 16'd0);
        done1(2'd2);
        chk("t2_busy_cleared", {12'd0, busy}, 16'h0);
        chk("t2_issue", {15'd0, issue_valid}, 16'd1);
        chk("t2_op", {12'd0, issue_op_code}, 16'd2);
        cyc();
        chk("t2_busy", {12'd0, busy}, 16'h2);
        done1(2'd1);

        // NOP between independent ops
        in_valid = 1'b1; in_instruction = 8'h10; cyc();
        in_instruction = 8'h05; cyc();
        chk("t3_nop_no_issue", {15'd0, issue_valid}, 16'd0);
        in_instruction = 8'h3F; cyc();
        in_valid = 1'b0;
        cyc();
        chk("t3_busy", {12'd0, busy}, 16'h9);
        chk("t3_count", {13'd0, fifo_count}, 16'd0);
        done1(2'd0);
        done1(2'd3);

        // HALT drain and resume
        in_valid = 1'b1; in_instruction = 8'h16; cyc();
        in_instruction = 8'hF0; cyc();
        in_instruction = 8'h20; cyc();
        in_valid = 1'b0;
        cyc();
        chk("t4_wait_halted", {15'd0, halted}, 16'd0);
        chk("t4_wait_count", {13'd0, fifo_count}, 16'd2);
        done1(2'd2);
        cyc();
        chk("t4_halted", {15'd0, halted}, 16'd1);
        chk("t4_no_issue", {15'd0, issue_valid}, 16'd0);
        chk("t4_count", {13'd0, fifo_count}, 16'd1);
        cyc();
        chk("t4_still_halted", {15'd0, halted}, 16'd1);
        resume = 1'b1; cyc(); resume = 1'b0;
        chk("t4_resumed", {15'd0, halted}, 16'd0);
        chk("t4_issue_20", {15'd0, issue_valid}, 16'd1);
        chk("t4_op_20", {12'd0, issue_op_code}, 16'd2);
        cyc();
        chk("t4_busy", {12'd0, busy}, 16'h1);
        done1(2'd0);

        // Fill to full, then pop with in_valid held
        issue_ready = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_instruction = 8'h10 + 8'(i);
            cyc();
        end
        in_instruction = 8'h14;
        chk("t5_full_count", {13'd0, fifo_count}, 16'd4);
        chk("t5_full_ready", {15'd0, in_ready}, 16'd0);
        cyc();
        chk("t5_still_full", {13'd0, fifo_count}, 16'd4);
        issue_ready = 1'b1;
        in_instruction = 8'h15;
        cyc();
        in_valid = 1'b0;
        issue_ready = 1'b0;
        chk("t5_pop_count", {13'd0, fifo_count}, 16'd3);
        chk("t5_pop_ready", {15'd0, in_ready}, 16'd1);
        chk("t5_head", {12'd0, issue_op_code}, 16'd1);
        chk("t5_head_src_dst", {12'd0, issue_src, issue_dst}, 16'h1);

        // Asynchronous reset mid-stream
        rst = 1'b1;
        #1;
        chk("t6_rst_count", {13'd0, fifo_count}, 16'd0);
        chk("t6_rst_busy", {12'd0, busy}, 16'd0);
        chk("t6_rst_issue", {15'd0, issue_valid}, 16'd0);
        chk("t6_rst_ready", {15'd0, in_ready}, 16'd0);
        cyc();
        rst = 1'b0;
        cyc();

        // Same-cycle set and clear of r2: set wins
        issue_ready = 1'b1;
        push1(8'h16);
        done_valid = 1'b1; done_dst = 2'd2;
        cyc();
        done_valid = 1'b0;
        chk("t6_set_wins", {12'd0, busy}, 16'h4);
        cyc();
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
